// File: rtl/hh_stdp_pkg.sv
// Shared widths, default constants and saturating helpers for the two-neuron STDP core.
package hh_stdp_pkg;

  localparam int V_W    = 16;
  localparam int I_W    = 8;
  localparam int W_W    = 8;
  localparam int TR_W   = 8;
  localparam int REFR_W = 3;
  // Membrane arithmetic is done two bits wider so the sum never wraps before saturation.
  localparam int EXT_W  = V_W + 2;

  localparam logic [V_W-1:0]    THRESH      = 16'h8000;
  localparam int                LEAK_SHIFT  = 4;
  localparam int                I_SHIFT     = 6;
  localparam logic [REFR_W-1:0] REFRACT     = 3'd4;
  localparam logic [W_W-1:0]    W_INIT      = 8'h40;
  localparam logic [TR_W-1:0]   TRACE_DECAY = 8'd16;
  localparam logic [TR_W-1:0]   TRACE_MAX   = 8'hFF;
  localparam int                STDP_SHIFT  = 4;

  typedef struct packed {
    logic [V_W-1:0] v;
    logic           spike;
    logic           fire;
  } neuron_obs_t;

  function automatic logic [W_W-1:0] sat_add(input logic [W_W-1:0] a, input logic [W_W-1:0] b);
    logic [W_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W_W] ? {W_W{1'b1}} : s[W_W-1:0];
  endfunction

  function automatic logic [W_W-1:0] sat_sub(input logic [W_W-1:0] a, input logic [W_W-1:0] b);
    return (b > a) ? {W_W{1'b0}} : (a - b);
  endfunction

endpackage

// File: rtl/hh_stdp_pair_lif_neuron.sv
// Leaky integrate-and-fire neuron: 16-bit saturating membrane, threshold reset, refractory hold.
module lif_neuron
  import hh_stdp_pkg::*;
#(
  parameter logic [V_W-1:0]    THRESH_P  = THRESH,
  parameter int                LEAK_P    = LEAK_SHIFT,
  parameter int                ISHIFT_P  = I_SHIFT,
  parameter logic [REFR_W-1:0] REFRACT_P = REFRACT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [I_W-1:0]   i_in,
  input  logic [EXT_W-1:0] syn_in,
  output neuron_obs_t      obs
);

  localparam logic [REFR_W-1:0] REFR_ONE = {{(REFR_W-1){1'b0}}, 1'b1};

  logic [V_W-1:0]    v_q, v_d;
  logic [REFR_W-1:0] refr_q, refr_d;
  logic              spike_q, spike_d;
  logic              fire;

  logic [EXT_W-1:0] v_ext;
  logic [EXT_W-1:0] leak;
  logic [EXT_W-1:0] drive;
  logic [EXT_W-1:0] sum;
  logic [V_W-1:0]   v_sat;

  always_comb begin
    v_ext = {{(EXT_W-V_W){1'b0}}, v_q};
    leak  = v_ext >> LEAK_P;
    drive = {{(EXT_W-I_W){1'b0}}, i_in} << ISHIFT_P;
    sum   = v_ext - leak + drive + syn_in;
    v_sat = (sum[EXT_W-1:V_W] != '0) ? {V_W{1'b1}} : sum[V_W-1:0];
  end

  // fire marks the enabled edge on which the spike register will become 1.
  always_comb begin
    v_d     = v_q;
    refr_d  = refr_q;
    spike_d = spike_q;
    fire    = 1'b0;
    if (ena) begin
      if (refr_q != '0) begin
        v_d     = '0;
        spike_d = 1'b0;
        refr_d  = refr_q - REFR_ONE;
      end else if (v_sat >= THRESH_P) begin
        v_d     = '0;
        spike_d = 1'b1;
        refr_d  = REFRACT_P;
        fire    = 1'b1;
      end else begin
        v_d     = v_sat;
        spike_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      refr_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
    end
  end

  always_comb begin
    obs.v     = v_q;
    obs.spike = spike_q;
    obs.fire  = fire;
  end

endmodule

// File: rtl/hh_stdp_pair.sv
// Two LIF neurons with one plastic N1->N2 synapse adapted by pair-based STDP traces.
module hh_stdp_pair
  import hh_stdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [I_W-1:0]   i_n   [2];
  logic [EXT_W-1:0] syn_n [2];
  neuron_obs_t      obs_n [2];

  logic [W_W-1:0]  w_q, w_d;
  logic [TR_W-1:0] pre_trace_q, pre_trace_d;
  logic [TR_W-1:0] post_trace_q, post_trace_d;
  logic            fire1, fire2;

  assign i_n[0] = ui_in;
  assign i_n[1] = uio_in;

  // N2 sees the weighted current only while the registered N1 spike is high.
  assign syn_n[0] = '0;
  assign syn_n[1] = obs_n[0].spike ? ({{(EXT_W-W_W){1'b0}}, w_q} << I_SHIFT) : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_neuron
      lif_neuron u_neuron (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .i_in   (i_n[gi]),
        .syn_in (syn_n[gi]),
        .obs    (obs_n[gi])
      );
    end
  endgenerate

  assign fire1 = obs_n[0].fire;
  assign fire2 = obs_n[1].fire;

  // STDP reads the traces as they stood before this edge; coincident spikes cancel.
  always_comb begin
    pre_trace_d  = pre_trace_q;
    post_trace_d = post_trace_q;
    w_d          = w_q;
    if (ena) begin
      pre_trace_d  = fire1 ? TRACE_MAX : sat_sub(pre_trace_q, TRACE_DECAY);
      post_trace_d = fire2 ? TRACE_MAX : sat_sub(post_trace_q, TRACE_DECAY);
      if (fire1 && fire2) begin
        w_d = w_q;
      end else if (fire2 && (pre_trace_q != '0)) begin
        w_d = sat_add(w_q, pre_trace_q >> STDP_SHIFT);
      end else if (fire1 && (post_trace_q != '0)) begin
        w_d = sat_sub(w_q, post_trace_q >> STDP_SHIFT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q          <= W_INIT;
      pre_trace_q  <= '0;
      post_trace_q <= '0;
    end else begin
      w_q          <= w_d;
      pre_trace_q  <= pre_trace_d;
      post_trace_q <= post_trace_d;
    end
  end

  assign uo_out  = obs_n[0].v[15:8];
  assign uio_out = {obs_n[0].spike, obs_n[1].spike, obs_n[1].v[15:10]};
  assign uio_oe  = 8'hFF;

  logic unused_v_bits;
  assign unused_v_bits = ^{obs_n[0].v[7:0], obs_n[1].v[9:0]};

endmodule

// File: tb/tb_hh_stdp_pair.sv
// Directed scoreboard bench for hh_stdp_pair: stimulus queues expected outputs, a monitor checks them.
module tb_hh_stdp_pair;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  hh_stdp_pair dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] w;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Monitor: every clock edge that has an expectation queued is checked 1 time unit later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({uo_out, uio_out, uio_oe, dut.w_q} === {e.uo, e.uio, 8'hFF, e.w}) begin
          passes++;
          $display("ok   %-14s uo=%h uio=%h oe=%h w=%h", e.name, uo_out, uio_out, uio_oe, dut.w_q);
        end else begin
          $display("FAIL %-14s got uo=%h uio=%h oe=%h w=%h, expected uo=%h uio=%h oe=FF w=%h",
                   e.name, uo_out, uio_out, uio_oe, dut.w_q, e.uo, e.uio, e.w);
        end
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] euo, input logic [7:0] euio, input logic [7:0] ew,
                      input string nm);
    rst    = r;
    ena    = en;
    ui_in  = a;
    uio_in = b;
    exp_q.push_back('{uo: euo, uio: euio, w: ew, name: nm});
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int spikes;
    int last_spike;
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    @(negedge clk);

    // Reset state
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset0");
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset1");

    // N1 driven by E0: spike on 3rd edge, N2 picks up w<<6 one edge later
    step(0, 1, 8'hE0, 8'h00, 8'h38, 8'h00, 8'h40, "hold_e1");
    step(0, 1, 8'hE0, 8'h00, 8'h6C, 8'h00, 8'h40, "hold_e2");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h80, 8'h40, "hold_spike1");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h04, 8'h40, "hold_syn");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h03, 8'h40, "hold_refr2");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h03, 8'h40, "hold_refr3");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h03, 8'h40, "hold_refr4");
    step(0, 1, 8'hE0, 8'h00, 8'h38, 8'h03, 8'h40, "hold_e8");
    step(0, 1, 8'hE0, 8'h00, 8'h6C, 8'h02, 8'h40, "hold_e9");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h82, 8'h40, "hold_spike2nd");

    // Spike rate over 100 edges of constant E0 drive
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset_rate");
    spikes = 0;
    last_spike = 0;
    for (int i = 1; i <= 100; i++) begin
      rst = 1'b0; ena = 1'b1; ui_in = 8'hE0; uio_in = 8'h00;
      @(negedge clk);
      if (uio_out[7]) begin
        spikes++;
        last_spike = i;
      end
    end
    checks++;
    if (spikes == 14) passes++;
    else $display("FAIL spike_count got %0d required 14", spikes);
    checks++;
    if (last_spike == 94) passes++;
    else $display("FAIL last_spike_edge got %0d required 94", last_spike);
    $display("ok?  spike_rate counted %0d spikes, last at edge %0d", spikes, last_spike);

    // Leak: one pulse then decay
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset_leak");
    step(0, 1, 8'hE0, 8'h00, 8'h38, 8'h00, 8'h40, "leak_e1");
    step(0, 1, 8'h00, 8'h00, 8'h34, 8'h00, 8'h40, "leak_e2");
    step(0, 1, 8'h00, 8'h00, 8'h31, 8'h00, 8'h40, "leak_e3");

    // Potentiation: spike1 then spike2 two edges later -> 0x40 + (0xEF>>4)
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset_pot");
    step(0, 1, 8'hE0, 8'hFF, 8'h38, 8'h0F, 8'h40, "pot_e1");
    step(0, 1, 8'hE0, 8'hFF, 8'h6C, 8'h1E, 8'h40, "pot_e2");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h9C, 8'h40, "pot_spike1");
    step(0, 1, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h40, "pot_syn");
    step(0, 1, 8'h00, 8'hFF, 8'h00, 8'h40, 8'h4E, "pot_spike2");

    // Depression: spike2 then spike1 two edges later -> 0x40 - (0xEF>>4)
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset_dep");
    step(0, 1, 8'h00, 8'hFF, 8'h00, 8'h0F, 8'h40, "dep_e1");
    step(0, 1, 8'h00, 8'hFF, 8'h00, 8'h1E, 8'h40, "dep_e2");
    step(0, 1, 8'hE0, 8'hFF, 8'h38, 8'h40, 8'h40, "dep_spike2");
    step(0, 1, 8'hE0, 8'h00, 8'h6C, 8'h00, 8'h40, "dep_e4");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h80, 8'h32, "dep_spike1");
    step(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, "dep_syn_refr");

    // Simultaneous spikes with both traces nonzero -> w unchanged
    step(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, "sim_e7");
    step(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, "sim_e8");
    step(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, "sim_e9");
    step(0, 1, 8'hE0, 8'hFF, 8'h38, 8'h0F, 8'h32, "sim_e10");
    step(0, 1, 8'hE0, 8'hFF, 8'h6C, 8'h1E, 8'h32, "sim_e11");
    step(0, 1, 8'hE0, 8'hFF, 8'h00, 8'hC0, 8'h32, "sim_both");

    // Enable gating: freeze mid-integration and while the spike register is high
    step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "reset_ena");
    step(0, 1, 8'hE0, 8'h00, 8'h38, 8'h00, 8'h40, "ena_e1");
    step(0, 0, 8'hE0, 8'h00, 8'h38, 8'h00, 8'h40, "ena_hold1");
    step(0, 0, 8'hE0, 8'h00, 8'h38, 8'h00, 8'h40, "ena_hold2");
    step(0, 0, 8'hE0, 8'h00, 8'h38, 8'h00, 8'h40, "ena_hold3");
    step(0, 1, 8'hE0, 8'h00, 8'h6C, 8'h00, 8'h40, "ena_resume");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h80, 8'h40, "ena_spike1");
    step(0, 0, 8'hE0, 8'h00, 8'h00, 8'h80, 8'h40, "ena_hold_spk1");
    step(0, 0, 8'hE0, 8'h00, 8'h00, 8'h80, 8'h40, "ena_hold_spk2");
    step(0, 1, 8'hE0, 8'h00, 8'h00, 8'h04, 8'h40, "ena_syn");
    step(1, 0, 8'hE0, 8'hFF, 8'h00, 8'h00, 8'h40, "rst_while_ena0");

    rst = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
